l3_refill_ctrl: RTL
===================

# l3_refill_ctrl

Miss/refill controller between the L2-side requester and the L3 cache on one side and main RAM on the other. It looks up each request in L3 and returns the full line on a read hit. On a read miss it fetches the line from RAM one word at a time, installs it into L3 with a single-cycle fill, and returns the line. Writes go through to RAM: L3 updates on a hit, and a write miss does not allocate.

## Interface
- DATA_WIDTH, 32, word width; L3 and RAM word size
- ADDR_WIDTH, 32, byte address width
- LINE_SIZE, 16, line bytes; WORDS_PER_LINE = LINE_SIZE/(DATA_WIDTH/8) = 4
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = write word, 0 = read line
- req_addr  in  ADDR_WIDTH  byte address
- req_w_data  in  DATA_WIDTH  write word
- resp_valid  out  1  one-cycle completion pulse
- resp_line  out  LINE_SIZE*8  read line; all zeros for writes
- l3_valid, l3_we  out  1  L3 lookup strobe, L3 write-hit enable
- l3_addr  out  ADDR_WIDTH  captured request address
- l3_w_data  out  DATA_WIDTH  captured write word
- l3_r_data  in  LINE_SIZE*8  L3 hit line, combinational
- l3_hit  in  1  L3 hit, combinational
- fill_en, fill_mark_valid  out  1  L3 fill strobes
- fill_addr  out  ADDR_WIDTH  line base, offset bits zero
- fill_data  out  LINE_SIZE*8  assembled line
- ram_req, ram_we  out  1  RAM request, RAM write
- ram_addr  out  ADDR_WIDTH  word address
- ram_w_data  out  DATA_WIDTH  write word
- ram_ack  in  1  completes the transfer in the cycle where ram_req && ram_ack
- ram_r_data  in  DATA_WIDTH  valid when ram_req && ram_ack && !ram_we
- hit_cnt, miss_cnt  out  32  read hit/miss counters; wrap modulo 2^32

## Operation
- States: IDLE, LOOKUP, FETCH, FILL, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, capture we/addr/w_data and go to LOOKUP.
- LOOKUP:
  - Drive l3_valid=1, l3_we=we, l3_addr, l3_w_data for exactly one cycle.
  - Sample l3_hit in this cycle.
  - Read hit: register l3_r_data into the line buffer, hit_cnt++, go to RESP.
  - Read miss: clear word counter, miss_cnt++, go to FETCH.
  - Write, hit or miss: go to WRITE. L3 performs its own word update on a hit.
- FETCH:
  - ram_req=1, ram_we=0, ram_addr = line base + 4*cnt.
  - On ack, store ram_r_data at buffer bits [32*cnt+31 : 32*cnt] and increment cnt.
  - After the ack with cnt=WORDS_PER_LINE-1, go to FILL.
- FILL: fill_en=fill_mark_valid=1 for one cycle, fill_addr = line base, fill_data = buffer. Go to RESP.
- WRITE: ram_req=1, ram_we=1, ram_addr = captured addr with bits [1:0] zeroed, ram_w_data = captured word. On ack, go to RESP.
- RESP: resp_valid=1 for one cycle; resp_line = buffer for reads, 0 for writes. Go to IDLE.
- ram_req, ram_addr and ram_we stay stable until ack. Counter and buffer do not change while waiting.
- req_valid while not in IDLE is ignored; the requester holds the request.

## Timing
- Reset, asynchronous and mid-operation included:
  - State returns to IDLE; buffer, counter and counters clear to 0.
  - Every output is 0 except req_ready=1.
  - An in-flight RAM request is dropped. The RAM side must tolerate ram_req falling without an ack.
- Read-hit latency: accepted at edge T, LOOKUP in cycle T+1, resp_valid in cycle T+2.
- Read-miss latency with zero-wait RAM (ack in the same cycle): LOOKUP, 4 FETCH cycles, FILL, RESP, so resp_valid comes 7 cycles after accept. Each RAM wait cycle adds 1.
- Write latency with zero-wait RAM: LOOKUP, WRITE, RESP, so resp_valid comes 3 cycles after accept.
- Unaligned addresses: fetch and fill use the line base. Byte offset bits are ignored except for word select inside L3.
- Word counter width is $clog2(WORDS_PER_LINE). It wraps to 0 on the final ack.
- fill_en never coincides with l3_valid.
- Back-to-back requests: the next request can be accepted in the cycle after RESP.

## Structure
- Shared package l3_pkg holds:
  - LINE_SIZE, WORDS_PER_LINE, LINE_BITS, OFFSET_BITS;
  - typedef enum refill_state_t {IDLE, LOOKUP, FETCH, FILL, WRITE, RESP};
  - the line_base() function that zeroes the offset bits.
- The l3 cache module imports the same package constants.
- One sub-module, l3_line_buffer:
  - word-indexed load port and full-line load port;
  - owns the buffer and the word counter.
- The top level holds the FSM and the counters.

## Test plan
- Read miss at 0x0000_1234, RAM returning 0xA0, 0xA1, 0xA2, 0xA3 with zero wait:
  - ram_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C;
  - fill_addr=0x1230 with fill_data=0x000000A3_000000A2_000000A1_000000A0;
  - resp_line equals fill_data, resp_valid 7 cycles after accept, miss_cnt=1.
- Repeat the same read with l3_hit=1 and l3_r_data equal to that line: resp_valid in cycle T+2, no ram_req, hit_cnt=1.
- Write 0xDEADBEEF to 0x0000_2006 with l3_hit=1:
  - l3_we=1 for one cycle;
  - ram_we with ram_addr=0x2004 and ram_w_data=0xDEADBEEF;
  - resp_line=0, no fill_en.
- Read miss with RAM acks delayed 3 cycles each: address and request held stable across the waits, resp_valid 19 cycles after accept.
- rst_n driven low after the second FETCH ack, then released: outputs return to reset values immediately; a new read re-fetches from word 0.
- req_valid held high for 10 cycles during a miss: only one request accepted; req_ready=0 until RESP completes.

Source files
------------

// File: rtl/l3_pkg.sv
// l3_pkg: shared line geometry, refill FSM states and line-base helper.
package l3_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_SIZE = 16;
  localparam int WORDS_PER_LINE = LINE_SIZE / (DATA_WIDTH / 8);
  localparam int LINE_BITS = LINE_SIZE * 8;
  localparam int OFFSET_BITS = $clog2(LINE_SIZE);
  localparam int CNT_BITS = $clog2(WORDS_PER_LINE);
  typedef enum logic [2:0] {IDLE, LOOKUP, FETCH, FILL, WRITE, RESP} refill_state_t;
  function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/l3_refill_ctrl_if.sv
// l3_refill_ctrl_if: requester, L3 and RAM signals of the refill controller.
interface l3_refill_ctrl_if;
  import l3_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_w_data;
  logic resp_valid;
  logic [LINE_BITS-1:0] resp_line;
  logic l3_valid;
  logic l3_we;
  logic [ADDR_WIDTH-1:0] l3_addr;
  logic [DATA_WIDTH-1:0] l3_w_data;
  logic [LINE_BITS-1:0] l3_r_data;
  logic l3_hit;
  logic fill_en;
  logic fill_mark_valid;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [LINE_BITS-1:0] fill_data;
  logic ram_req;
  logic ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_w_data;
  logic ram_ack;
  logic [DATA_WIDTH-1:0] ram_r_data;
  modport master (
    input req_valid, req_we, req_addr, req_w_data, l3_r_data, l3_hit, ram_ack, ram_r_data,
    output req_ready, resp_valid, resp_line, l3_valid, l3_we, l3_addr, l3_w_data,
    output fill_en, fill_mark_valid, fill_addr, fill_data, ram_req, ram_we, ram_addr, ram_w_data
  );
  modport slave (
    output req_valid, req_we, req_addr, req_w_data, l3_r_data, l3_hit, ram_ack, ram_r_data,
    input req_ready, resp_valid, resp_line, l3_valid, l3_we, l3_addr, l3_w_data,
    input fill_en, fill_mark_valid, fill_addr, fill_data, ram_req, ram_we, ram_addr, ram_w_data
  );
endinterface

// File: rtl/l3_line_buffer.sv
// l3_line_buffer: line assembly buffer with word-indexed and full-line load, plus word counter.
module l3_line_buffer
  import l3_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  word_we_i,
  input  logic                  line_we_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [LINE_BITS-1:0]  line_i,
  output logic [CNT_BITS-1:0]   cnt_o,
  output logic [LINE_BITS-1:0]  line_o
);
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  always_comb begin
    line_d = line_q;
    cnt_d = clr_i ? '0 : cnt_q;
    if (line_we_i) line_d = line_i;
    if (word_we_i) begin
      line_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = word_i;
      cnt_d = CNT_BITS'(cnt_q + 1'b1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt_q <= '0;
    end else begin
      line_q <= line_d;
      cnt_q <= cnt_d;
    end
  end
  assign cnt_o = cnt_q;
  assign line_o = line_q;
endmodule

// File: rtl/l3_refill_ctrl.sv
// l3_refill_ctrl: L3 lookup with line refill from RAM on read miss; writes go through to RAM.
module l3_refill_ctrl
  import l3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  l3_refill_ctrl_if.master  bus,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);
  refill_state_t state_q, state_d;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [31:0] hit_q, hit_d, miss_q, miss_d;
  logic [CNT_BITS-1:0] cnt;
  logic [LINE_BITS-1:0] line;
  logic lookup, rd_hit, rd_miss, ack, fetch, fill, wr, resp;
  assign lookup = state_q == LOOKUP;
  assign fetch = state_q == FETCH;
  assign fill = state_q == FILL;
  assign wr = state_q == WRITE;
  assign resp = state_q == RESP;
  assign rd_hit = lookup && !we_q && bus.l3_hit;
  assign rd_miss = lookup && !we_q && !bus.l3_hit;
  assign ack = bus.ram_req && bus.ram_ack;
  l3_line_buffer u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .clr_i(rd_miss),
    .word_we_i(fetch && ack),
    .line_we_i(rd_hit),
    .word_i(bus.ram_r_data),
    .line_i(bus.l3_r_data),
    .cnt_o(cnt),
    .line_o(line)
  );
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    w_data_d = w_data_q;
    hit_d = hit_q + 32'(rd_hit);
    miss_d = miss_q + 32'(rd_miss);
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = LOOKUP;
        we_d = bus.req_we;
        addr_d = bus.req_addr;
        w_data_d = bus.req_w_data;
      end
      LOOKUP: state_d = we_q ? WRITE : bus.l3_hit ? RESP : FETCH;
      FETCH: if (ack && cnt == CNT_BITS'(WORDS_PER_LINE - 1)) state_d = FILL;
      FILL: state_d = RESP;
      WRITE: if (ack) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      w_data_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      w_data_q <= w_data_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
  // Data outputs are gated by state so every output is zero outside its own phase.
  assign bus.req_ready = state_q == IDLE;
  assign bus.l3_valid = lookup;
  assign bus.l3_we = lookup && we_q;
  assign bus.l3_addr = lookup ? addr_q : '0;
  assign bus.l3_w_data = lookup ? w_data_q : '0;
  assign bus.fill_en = fill;
  assign bus.fill_mark_valid = fill;
  assign bus.fill_addr = fill ? line_base(addr_q) : '0;
  assign bus.fill_data = fill ? line : '0;
  assign bus.ram_req = fetch || wr;
  assign bus.ram_we = wr;
  assign bus.ram_addr = fetch ? line_base(addr_q) + (ADDR_WIDTH'(cnt) << 2)
                      : wr ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.ram_w_data = wr ? w_data_q : '0;
  assign bus.resp_valid = resp;
  assign bus.resp_line = (resp && !we_q) ? line : '0;
  assign hit_cnt_o = hit_q;
  assign miss_cnt_o = miss_q;
endmodule
